uart_rx_cfg: RTL and testbench

- Parametrised successor to the fixed 8N1 UART receiver.
- Configurable data width, optional odd/even parity, one or two stop bits.
- Adds an input synchroniser, start-bit glitch rejection, and parity/framing error reporting.
- Sits between the board RX pin and byte-level consumers (command parser, RX FIFO); one instance per serial channel.

---
 rtl/uart_rx_cfg.sv | 257 +++++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// uart_rx_cfg -- parametrised asynchronous serial receiver
//
// Receives frames of g_DATA_BITS data bits (LSB first), an optional odd/even
// parity bit and g_STOP_BITS stop bits. The line passes through a two-flop
// synchroniser. A start bit must still be low at mid-bit, otherwise it is
// rejected as a glitch. Frames with parity or framing errors are still
// delivered.
//
// Optional feature (macro UART_RX_BREAK_DETECT_EN): a frame that samples 0
// for every bit raises o_Break. The receiver then ignores the line until it
// has been high for a full bit period. Without the macro o_Break is tied to 0.
//
// Ports:
//   i_Clk        system clock, rising edge
//   i_Rst        synchronous active-high reset
//   i_RX_Serial  asynchronous serial input, idle high
//   o_RX_DV      one-cycle pulse, frame complete
//   o_RX_Byte    received data, held until next o_RX_DV
//   o_Parity_Err parity mismatch on last frame
//   o_Frame_Err  a stop bit sampled low on last frame
//   o_Busy       receiver not idle
//   o_Break      break detected (optional feature)
// ---------------------------------------------------------------------------
module uart_rx_cfg #(
    parameter int g_CLKS_PER_BIT = 10417,
    parameter int g_DATA_BITS    = 8,
    parameter int g_PARITY       = 0,
    parameter int g_STOP_BITS    = 1
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_RX_Serial,
    output logic                   o_RX_DV,
    output logic [g_DATA_BITS-1:0] o_RX_Byte,
    output logic                   o_Parity_Err,
    output logic                   o_Frame_Err,
    output logic                   o_Busy,
    output logic                   o_Break
);

    localparam int CNT_W = $clog2(g_CLKS_PER_BIT);
    localparam int IDX_W = $clog2(g_DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(g_CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((g_CLKS_PER_BIT - 1) / 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(g_DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(g_STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CLEANUP} state_t;

    state_t                 state_reg, state_next;
    logic                   rx_meta_reg, rx_s_reg;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic [g_DATA_BITS-1:0] shift_reg, shift_next;
    logic                   par_err_reg, par_err_next;
    logic                   frm_err_reg, frm_err_next;
    logic                   dv_reg, dv_next;
    logic [g_DATA_BITS-1:0] byte_reg, byte_next;
    logic                   perr_out_reg, perr_out_next;
    logic                   ferr_out_reg, ferr_out_next;
    logic                   busy_reg, busy_next;
    logic                   bit_tick;
    logic                   load_frame;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                   zero_reg, zero_next;      // every sample so far was 0
    logic                   hold_reg, hold_next;      // waiting for line to recover
    logic                   brk_reg, brk_next;
`endif

    assign bit_tick = (cnt_reg == CNT_LAST);

    // State register and datapath registers
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            rx_meta_reg  <= 1'b1;
            rx_s_reg     <= 1'b1;
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            shift_reg    <= '0;
            par_err_reg  <= 1'b0;
            frm_err_reg  <= 1'b0;
            dv_reg       <= 1'b0;
            byte_reg     <= '0;
            perr_out_reg <= 1'b0;
            ferr_out_reg <= 1'b0;
            busy_reg     <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            zero_reg     <= 1'b0;
            hold_reg     <= 1'b0;
            brk_reg      <= 1'b0;
`endif
        end else begin
            rx_meta_reg  <= i_RX_Serial;
            rx_s_reg     <= rx_meta_reg;
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            shift_reg    <= shift_next;
            par_err_reg  <= par_err_next;
            frm_err_reg  <= frm_err_next;
            dv_reg       <= dv_next;
            byte_reg     <= byte_next;
            perr_out_reg <= perr_out_next;
            ferr_out_reg <= ferr_out_next;
            busy_reg     <= busy_next;
`ifdef UART_RX_BREAK_DETECT_EN
            zero_reg     <= zero_next;
            hold_reg     <= hold_next;
            brk_reg      <= brk_next;
`endif
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        idx_next     = idx_reg;
        shift_next   = shift_reg;
        par_err_next = par_err_reg;
        frm_err_next = frm_err_reg;
`ifdef UART_RX_BREAK_DETECT_EN
        zero_next    = zero_reg;
        hold_next    = hold_reg;
`endif
        case (state_reg)
            IDLE: begin
`ifdef UART_RX_BREAK_DETECT_EN
                // After a break the counter measures continuous high time;
                // any low sample restarts the measurement.
                if (hold_reg) begin
                    if (!rx_s_reg) begin
                        cnt_next = '0;
                    end else if (bit_tick) begin
                        cnt_next  = '0;
                        hold_next = 1'b0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end else
`endif
                if (!rx_s_reg) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                if (cnt_reg == CNT_HALF) begin
                    cnt_next = '0;
                    if (!rx_s_reg) begin
                        state_next   = DATA;
                        idx_next     = '0;
                        par_err_next = 1'b0;
                        frm_err_next = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                        zero_next    = 1'b1;
`endif
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    cnt_next   = '0;
                    shift_next = {rx_s_reg, shift_reg[g_DATA_BITS-1:1]};
`ifdef UART_RX_BREAK_DETECT_EN
                    zero_next  = zero_reg & ~rx_s_reg;
`endif
                    if (idx_reg == IDX_LAST) begin
                        idx_next = '0;
                        if (g_PARITY != 0) state_next = PARITY;
                        else               state_next = STOP;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = STOP;
                    // XOR over data and parity: odd mode wants 1, even wants 0
                    if (g_PARITY == 1) par_err_next = ~(^shift_reg ^ rx_s_reg);
                    else               par_err_next = ^shift_reg ^ rx_s_reg;
`ifdef UART_RX_BREAK_DETECT_EN
                    zero_next  = zero_reg & ~rx_s_reg;
`endif
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    cnt_next = '0;
                    if (!rx_s_reg) frm_err_next = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
                    zero_next = zero_reg & ~rx_s_reg;
`endif
                    if (idx_reg == STOP_LAST) begin
                        state_next = CLEANUP;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            CLEANUP: begin
                state_next = IDLE;
                cnt_next   = '0;
`ifdef UART_RX_BREAK_DETECT_EN
                hold_next  = zero_reg;
`endif
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output logic: results are registered on the edge that enters CLEANUP,
    // so o_RX_DV and the data/flags become visible together during CLEANUP.
    always_comb begin
        load_frame    = (state_reg == STOP) && (state_next == CLEANUP);
        dv_next       = load_frame;
        byte_next     = load_frame ? shift_reg    : byte_reg;
        perr_out_next = load_frame ? par_err_next : perr_out_reg;
        ferr_out_next = load_frame ? frm_err_next : ferr_out_reg;
        busy_next     = (state_next != IDLE);
`ifdef UART_RX_BREAK_DETECT_EN
        if (load_frame)    brk_next = zero_next;
        else if (rx_s_reg) brk_next = 1'b0;
        else               brk_next = brk_reg;
`endif
    end

    assign o_RX_DV      = dv_reg;
    assign o_RX_Byte    = byte_reg;
    assign o_Parity_Err = perr_out_reg;
    assign o_Frame_Err  = ferr_out_reg;
    assign o_Busy       = busy_reg;
`ifdef UART_RX_BREAK_DETECT_EN
    assign o_Break      = brk_reg;
`else
    assign o_Break      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_cfg -- self-checking bench for uart_rx_cfg
//
// Three receivers share clock and reset, each with its own serial line:
//   u_a : 8N1, u_b : 8 data, even parity, 2 stop, u_c : 7N1 (all CPB = 16).
// A monitor records every o_RX_DV into a per-receiver queue; the checks
// pop those records and compare against hand-computed values.
// ---------------------------------------------------------------------------
module tb_uart_rx_cfg;

    localparam int CPB = 16;

    typedef struct {
        int unsigned sel;
        logic [8:0]  data;
        logic        par_bit;
        logic        stop2;
        logic [8:0]  exp_byte;
        logic        exp_perr;
        logic        exp_ferr;
    } vec_t;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } cap_t;

    logic       clk = 1'b0;
    logic       srst = 1'b1;
    logic [2:0] rx_line = 3'b111;

    logic       dv_a, perr_a, ferr_a, busy_a, brk_a;
    logic [7:0] byte_a;
    logic       dv_b, perr_b, ferr_b, busy_b, brk_b;
    logic [7:0] byte_b;
    logic       dv_c, perr_c, ferr_c, busy_c, brk_c;
    logic [6:0] byte_c;

    int total = 0;
    int bad = 0;
    int consec = 0;
    int brk_seen = 0;
    logic [2:0] prev_dv = 3'b000;
    cap_t q_a[$];
    cap_t q_b[$];
    cap_t q_c[$];

    always #5 clk = ~clk;

    uart_rx_cfg #(.g_CLKS_PER_BIT(CPB), .g_DATA_BITS(8), .g_PARITY(0), .g_STOP_BITS(1)) u_a (
        .i_Clk(clk), .i_Rst(srst), .i_RX_Serial(rx_line[0]),
        .o_RX_DV(dv_a), .o_RX_Byte(byte_a), .o_Parity_Err(perr_a),
        .o_Frame_Err(ferr_a), .o_Busy(busy_a), .o_Break(brk_a));

    uart_rx_cfg #(.g_CLKS_PER_BIT(CPB), .g_DATA_BITS(8), .g_PARITY(2), .g_STOP_BITS(2)) u_b (
        .i_Clk(clk), .i_Rst(srst), .i_RX_Serial(rx_line[1]),
        .o_RX_DV(dv_b), .o_RX_Byte(byte_b), .o_Parity_Err(perr_b),
        .o_Frame_Err(ferr_b), .o_Busy(busy_b), .o_Break(brk_b));

    uart_rx_cfg #(.g_CLKS_PER_BIT(CPB), .g_DATA_BITS(7), .g_PARITY(0), .g_STOP_BITS(1)) u_c (
        .i_Clk(clk), .i_Rst(srst), .i_RX_Serial(rx_line[2]),
        .o_RX_DV(dv_c), .o_RX_Byte(byte_c), .o_Parity_Err(perr_c),
        .o_Frame_Err(ferr_c), .o_Busy(busy_c), .o_Break(brk_c));

    // Capture every DV pulse; also note back-to-back pulses and any break
    always @(negedge clk) begin
        if (dv_a) q_a.push_back('{data: {1'b0, byte_a}, perr: perr_a, ferr: ferr_a, brk: brk_a});
        if (dv_b) q_b.push_back('{data: {1'b0, byte_b}, perr: perr_b, ferr: ferr_b, brk: brk_b});
        if (dv_c) q_c.push_back('{data: {2'b00, byte_c}, perr: perr_c, ferr: ferr_c, brk: brk_c});
        if ((prev_dv & {dv_c, dv_b, dv_a}) != 3'b000) consec = consec + 1;
        if (brk_a | brk_b | brk_c) brk_seen = brk_seen + 1;
        prev_dv <= {dv_c, dv_b, dv_a};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int q_size(input int unsigned sel);
        case (sel)
            0: return q_a.size();
            1: return q_b.size();
            default: return q_c.size();
        endcase
    endfunction

    task automatic expect_frame(input int unsigned sel, input string tag, input logic [8:0] eb,
                                input logic ep, input logic ef, input logic ebrk);
        cap_t c;
        int n;
        c = '{data: 9'h0, perr: 1'b0, ferr: 1'b0, brk: 1'b0};
        n = q_size(sel);
        if (n > 0) begin
            case (sel)
                0: c = q_a.pop_front();
                1: c = q_b.pop_front();
                default: c = q_c.pop_front();
            endcase
        end
        chk({tag, "_dv_seen"}, (n > 0), 1);
        if (n > 0) begin
            $display("frame %s: dut=%0d byte=%0h perr=%0d ferr=%0d brk=%0d", tag, sel,
                     c.data, c.perr, c.ferr, c.brk);
            chk({tag, "_byte"}, c.data, eb);
            chk({tag, "_perr"}, c.perr, ep);
            chk({tag, "_ferr"}, c.ferr, ef);
            chk({tag, "_brk"}, c.brk, ebrk);
        end
    endtask

    task automatic send_bit(input int unsigned sel, input logic b);
        rx_line[sel] = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input int unsigned sel, input logic [8:0] data,
                              input logic par_bit, input logic stop2);
        int nb;
        nb = (sel == 2) ? 7 : 8;
        send_bit(sel, 1'b0);
        for (int i = 0; i < nb; i++) send_bit(sel, data[i]);
        if (sel == 1) send_bit(sel, par_bit);
        send_bit(sel, 1'b1);
        if (sel == 1) send_bit(sel, stop2);
        rx_line[sel] = 1'b1;
    endtask

    vec_t vecs[9];

    initial begin
        int k;
        int seen;

        vecs[0] = '{sel: 0, data: 9'h037, par_bit: 0, stop2: 1, exp_byte: 9'h037, exp_perr: 0, exp_ferr: 0};
        vecs[1] = '{sel: 0, data: 9'h000, par_bit: 0, stop2: 1, exp_byte: 9'h000, exp_perr: 0, exp_ferr: 0};
        vecs[2] = '{sel: 0, data: 9'h0FF, par_bit: 0, stop2: 1, exp_byte: 9'h0FF, exp_perr: 0, exp_ferr: 0};
        vecs[3] = '{sel: 1, data: 9'h0A5, par_bit: 0, stop2: 1, exp_byte: 9'h0A5, exp_perr: 0, exp_ferr: 0};
        vecs[4] = '{sel: 1, data: 9'h0A5, par_bit: 1, stop2: 1, exp_byte: 9'h0A5, exp_perr: 1, exp_ferr: 0};
        vecs[5] = '{sel: 1, data: 9'h03C, par_bit: 0, stop2: 0, exp_byte: 9'h03C, exp_perr: 0, exp_ferr: 1};
        vecs[6] = '{sel: 1, data: 9'h081, par_bit: 0, stop2: 1, exp_byte: 9'h081, exp_perr: 0, exp_ferr: 0};
        vecs[7] = '{sel: 2, data: 9'h055, par_bit: 0, stop2: 1, exp_byte: 9'h055, exp_perr: 0, exp_ferr: 0};
        vecs[8] = '{sel: 1, data: 9'h001, par_bit: 1, stop2: 1, exp_byte: 9'h001, exp_perr: 0, exp_ferr: 0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_dv", dv_a, 0);
        chk("rst_byte", byte_a, 0);
        chk("rst_perr", perr_a, 0);
        chk("rst_ferr", ferr_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_brk", brk_a, 0);
        srst = 1'b0;
        repeat (5) @(negedge clk);

        // Table-driven frames
        for (int v = 0; v < 9; v++) begin
            send_frame(vecs[v].sel, vecs[v].data, vecs[v].par_bit, vecs[v].stop2);
            repeat (8) @(negedge clk);
            chk($sformatf("vec%0d_ndv", v), q_size(vecs[v].sel), 1);
            expect_frame(vecs[v].sel, $sformatf("vec%0d", v), vecs[v].exp_byte,
                         vecs[v].exp_perr, vecs[v].exp_ferr, 1'b0);
            chk($sformatf("vec%0d_idle", v),
                (vecs[v].sel == 0) ? busy_a : ((vecs[v].sel == 1) ? busy_b : busy_c), 0);
        end

        // Busy falls the cycle after the DV pulse; latency bound 156 clocks
        seen = 0;
        k = 0;
        fork
            send_frame(0, 9'h037, 1'b0, 1'b1);
            begin
                for (k = 1; k <= 200; k++) begin
                    @(negedge clk);
                    if (dv_a) break;
                end
                chk("lat_within_bound", (k <= 156), 1);
                chk("busy_during_dv", busy_a, 1);
                @(negedge clk);
                chk("dv_single_cycle", dv_a, 0);
                chk("busy_after_cleanup", busy_a, 0);
            end
        join
        repeat (4) @(negedge clk);
        expect_frame(0, "busyseq", 9'h037, 0, 0, 0);

        // Start glitch: low for 4 clocks
        rx_line[0] = 1'b0;
        seen = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (busy_a) seen = 1;
            if (i == 4) rx_line[0] = 1'b1;
        end
        chk("glitch_busy_seen", seen, 1);
        chk("glitch_busy_clear", busy_a, 0);
        repeat (200) @(negedge clk);
        chk("glitch_no_dv", q_size(0), 0);

        // Reset after the 3rd data bit of 0xFF
        fork
            send_frame(0, 9'h0FF, 1'b0, 1'b1);
            begin
                repeat (CPB * 4 + 8) @(negedge clk);
                srst = 1'b1;
                @(negedge clk);
                srst = 1'b0;
                chk("midrst_dv", dv_a, 0);
                chk("midrst_byte", byte_a, 0);
                chk("midrst_ferr", ferr_a, 0);
                chk("midrst_busy", busy_a, 0);
            end
        join
        repeat (20) @(negedge clk);
        chk("midrst_no_dv", q_size(0), 0);
        send_frame(0, 9'h05A, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        expect_frame(0, "after_rst", 9'h05A, 0, 0, 0);

        // Back-to-back 7-bit frames, no idle between them
        send_frame(2, 9'h000, 1'b0, 1'b1);
        send_frame(2, 9'h07F, 1'b0, 1'b1);
        send_frame(2, 9'h055, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        chk("b2b_ndv", q_size(2), 3);
        expect_frame(2, "b2b0", 9'h000, 0, 0, 0);
        expect_frame(2, "b2b1", 9'h07F, 0, 0, 0);
        expect_frame(2, "b2b2", 9'h055, 0, 0, 0);

        // Line held low for 3 frame times
        rx_line[0] = 1'b0;
        repeat (3 * 10 * CPB) @(negedge clk);
`ifdef UART_RX_BREAK_DETECT_EN
        chk("brk_held", brk_a, 1);
        rx_line[0] = 1'b1;
        repeat (6) @(negedge clk);
        chk("brk_cleared", brk_a, 0);
        chk("brk_ndv", q_size(0), 1);
        expect_frame(0, "brk", 9'h000, 0, 1, 1);
        // Still recovering (high only a few clocks): a full zero frame is ignored
        send_frame(0, 9'h000, 1'b0, 1'b1);
        repeat (30) @(negedge clk);
        chk("brk_hold_no_dv", q_size(0), 0);
        send_frame(0, 9'h05A, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        expect_frame(0, "post_brk", 9'h05A, 0, 0, 0);
`else
        rx_line[0] = 1'b1;
        repeat (200) @(negedge clk);
        chk("low_ndv_ge3", (q_size(0) >= 3), 1);
        expect_frame(0, "low0", 9'h000, 0, 1, 0);
        expect_frame(0, "low1", 9'h000, 0, 1, 0);
        expect_frame(0, "low2", 9'h000, 0, 1, 0);
        q_a.delete();
        chk("no_break_ever", brk_seen, 0);
`endif

        chk("no_consecutive_dv", consec, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
